// File: rtl/dft_pkg.sv
// Shared constants, FSM encoding and the packed-lane helper for the 8-point FFT frame sequencer.
package dft_pkg;

  localparam int FRAME_LEN  = 8;
  localparam int IDX_W      = 3;
  localparam int LANE_MAX_W = 32;
  localparam int LANE_BUS_W = FRAME_LEN * LANE_MAX_W;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } fsm_e;

  // Returns lane i (dw bits, dw <= LANE_MAX_W) of a packed bus zero-extended to LANE_BUS_W.
  function automatic logic [LANE_MAX_W-1:0] lane(input logic [LANE_BUS_W-1:0] bus,
                                                 input int dw,
                                                 input int i);
    logic [LANE_BUS_W-1:0] sh;
    sh = bus >> (i * dw);
    return sh[LANE_MAX_W-1:0] & ~({LANE_MAX_W{1'b1}} << dw);
  endfunction

endpackage

// File: rtl/dft_ref_model.sv
// Combinational reference of the 8-point radix-2 FFT butterfly network; all sums wrap at DW bits.
module dft_ref_model
  import dft_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [FRAME_LEN*DW-1:0] x,
  output logic [FRAME_LEN*DW-1:0] y
);

  logic [DW-1:0] xl [FRAME_LEN];
  logic [DW-1:0] yl [FRAME_LEN];

  for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_lane
    assign xl[gi] = DW'(lane(LANE_BUS_W'(x), DW, gi));
    assign y[gi*DW +: DW] = yl[gi];
  end

  logic [DW-1:0] p04, m04, p26, m26, p15, m15, p37, m37;

  // First butterfly stage pairs lanes four apart.
  assign p04 = xl[0] + xl[4];
  assign m04 = xl[0] - xl[4];
  assign p26 = xl[2] + xl[6];
  assign m26 = xl[2] - xl[6];
  assign p15 = xl[1] + xl[5];
  assign m15 = xl[1] - xl[5];
  assign p37 = xl[3] + xl[7];
  assign m37 = xl[3] - xl[7];

  assign yl[0] = p04 + p26;
  assign yl[1] = p15 + p37;
  assign yl[2] = m04 + m26;
  assign yl[3] = m15 - m37;
  assign yl[4] = p04 - p26;
  assign yl[5] = p15 - p37;
  assign yl[6] = m04 - m26;
  assign yl[7] = m15 + m37;

endmodule

// File: rtl/dft_frame_sequencer.sv
// Frame sequencer around the 8-point FFT: serial samples in, parallel FFT drive, buffered serial results out.
// Build macro DFT_SEQ_SELFCHECK_EN adds a reference-model check of every captured frame (err_count/err_flag).
module dft_frame_sequencer
  import dft_pkg::*;
#(
  parameter int DW          = 8,
  parameter int FFT_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_clr,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DW-1:0]           s_data,
  output logic [FRAME_LEN*DW-1:0] fft_x,
  input  logic [FRAME_LEN*DW-1:0] fft_y,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DW-1:0]           m_data,
  output logic [IDX_W-1:0]        m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic [CNT_W-1:0]        frame_count,
  output logic [7:0]              err_count,
  output logic                    err_flag
);

  localparam logic [1:0]       ST_FILL    = FILL;
  localparam logic [1:0]       ST_WAIT    = WAIT;
  localparam logic [1:0]       ST_CAPTURE = CAPTURE;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        in_idx_q, in_idx_d;
  logic                    s_ready_q, s_ready_d;
  logic [FRAME_LEN*DW-1:0] fft_x_q, fft_x_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [CNT_W-1:0]        frame_count_q, frame_count_d;

  logic [FRAME_LEN*DW-1:0] obuf_q, obuf_d;
  logic                    obuf_full_q, obuf_full_d;
  logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
  logic                    m_valid_q, m_valid_d;
  logic [DW-1:0]           m_data_q, m_data_d;
  logic [IDX_W-1:0]        m_index_q, m_index_d;

  logic accept;
  logic out_take;
  logic xfer;
  logic load;

  assign accept   = s_valid & s_ready_q;
  // The output register can take a new beat when it is empty or its beat leaves this cycle.
  assign out_take = ~m_valid_q | m_ready;
  assign xfer     = obuf_full_q & out_take;
  assign load     = (state_q == ST_CAPTURE)
                  & (~obuf_full_q | (xfer & (rd_idx_q == LAST_IDX)))
                  & ~sync_clr;

  always_comb begin
    state_d       = state_q;
    in_idx_d      = in_idx_q;
    s_ready_d     = s_ready_q;
    fft_x_d       = fft_x_q;
    wcnt_d        = wcnt_q;
    frame_count_d = frame_count_q;

    for (int i = 0; i < FRAME_LEN; i++) begin
      if (accept && (in_idx_q == IDX_W'(i))) begin
        fft_x_d[i*DW +: DW] = s_data;
      end
    end

    case (state_q)
      ST_FILL: begin
        s_ready_d = 1'b1;
        if (accept) begin
          in_idx_d = in_idx_q + IDX_W'(1);
          if (in_idx_q == LAST_IDX) begin
            s_ready_d = 1'b0;
            state_d   = ST_WAIT;
            wcnt_d    = 4'(FFT_LATENCY);
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd1) begin
          state_d = ST_CAPTURE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        if (load) begin
          state_d       = ST_FILL;
          in_idx_d      = '0;
          s_ready_d     = 1'b1;
          frame_count_d = frame_count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_FILL;
        in_idx_d  = '0;
        s_ready_d = 1'b1;
      end
    endcase

    if (sync_clr) begin
      state_d   = ST_FILL;
      in_idx_d  = '0;
      s_ready_d = 1'b1;
    end
  end

  always_comb begin
    obuf_d      = obuf_q;
    obuf_full_d = obuf_full_q;
    rd_idx_d    = rd_idx_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_index_d   = m_index_q;

    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = DW'(lane(LANE_BUS_W'(obuf_q), DW, int'(rd_idx_q)));
      m_index_d = rd_idx_q;
      rd_idx_d  = rd_idx_q + IDX_W'(1);
      if (rd_idx_q == LAST_IDX) begin
        obuf_full_d = 1'b0;
      end
    end else if (out_take) begin
      m_valid_d = 1'b0;
    end

    // A reload in the same cycle as the last beat leaves keeps m_valid continuous.
    if (load) begin
      obuf_d      = fft_y;
      obuf_full_d = 1'b1;
      rd_idx_d    = '0;
    end

    if (sync_clr) begin
      obuf_full_d = 1'b0;
      rd_idx_d    = '0;
      m_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      in_idx_q      <= '0;
      s_ready_q     <= 1'b0;
      fft_x_q       <= '0;
      wcnt_q        <= '0;
      frame_count_q <= '0;
      obuf_q        <= '0;
      obuf_full_q   <= 1'b0;
      rd_idx_q      <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_index_q     <= '0;
    end else begin
      state_q       <= state_d;
      in_idx_q      <= in_idx_d;
      s_ready_q     <= s_ready_d;
      fft_x_q       <= fft_x_d;
      wcnt_q        <= wcnt_d;
      frame_count_q <= frame_count_d;
      obuf_q        <= obuf_d;
      obuf_full_q   <= obuf_full_d;
      rd_idx_q      <= rd_idx_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_index_q     <= m_index_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign fft_x       = fft_x_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_index     = m_index_q;
  assign m_last      = m_valid_q & (m_index_q == LAST_IDX);
  assign busy        = (state_q != ST_FILL) | obuf_full_q | m_valid_q;
  assign frame_count = frame_count_q;

`ifdef DFT_SEQ_SELFCHECK_EN
  logic [FRAME_LEN*DW-1:0] ref_y;
  logic                    mismatch;
  logic [7:0]              err_count_q, err_count_d;
  logic                    err_flag_q, err_flag_d;

  dft_ref_model #(.DW(DW)) u_ref_model (
    .x (fft_x_q),
    .y (ref_y)
  );

  // load already excludes sync_clr, so an abort never touches the error state.
  assign mismatch = load & (ref_y != fft_y);

  always_comb begin
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign err_count = err_count_q;
  assign err_flag  = err_flag_q;
`else
  assign err_count = '0;
  assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Self-checking bench for dft_frame_sequencer: directed steps plus randomized frames against a sign-table FFT model.
module tb_dft_frame_sequencer;
  import dft_pkg::*;

  localparam int DW    = 8;
  localparam int LAT   = 2;
  localparam int CNT_W = 16;

  logic                    clk      = 1'b0;
  logic                    rst_n    = 1'b0;
  logic                    sync_clr = 1'b0;
  logic                    s_valid  = 1'b0;
  logic [DW-1:0]           s_data   = '0;
  logic                    m_ready  = 1'b0;
  logic                    s_ready, m_valid, m_last, busy, err_flag;
  logic [FRAME_LEN*DW-1:0] fft_x, fft_y, ref_y, d1, d2, flip_mask;
  logic [DW-1:0]           m_data;
  logic [IDX_W-1:0]        m_index;
  logic [CNT_W-1:0]        frame_count;
  logic [7:0]              err_count;

  int  compared   = 0;
  int  mismatched = 0;
  int  frames_exp = 0;
  bit  rand_rdy   = 1'b0;
  bit  bad_y3     = 1'b0;

  // Y[k] = sum over j of sgn[k][j] * X[j], taken modulo 2^DW.
  int sgn [8][8] = '{
    '{1, 0,  1,  0,  1,  0,  1,  0},
    '{0, 1,  0,  1,  0,  1,  0,  1},
    '{1, 0,  1,  0, -1,  0, -1,  0},
    '{0, 1,  0, -1,  0, -1,  0,  1},
    '{1, 0, -1,  0,  1,  0, -1,  0},
    '{0, 1,  0, -1,  0,  1,  0, -1},
    '{1, 0, -1,  0, -1,  0,  1,  0},
    '{0, 1,  0,  1,  0, -1,  0, -1}
  };

  logic [DW-1:0]   pend [$];
  logic [DW+3:0]   expq [$];

  always #5 clk = ~clk;

  dft_ref_model #(.DW(DW)) u_fft (
    .x (fft_x),
    .y (ref_y)
  );

  // FFT stand-in with LAT register stages and an optional Y3 bit-0 fault.
  always @(posedge clk) begin
    d1 <= ref_y;
    d2 <= d1;
  end
  assign flip_mask = bad_y3 ? ((FRAME_LEN*DW)'(1) << (3*DW)) : '0;
  assign fft_y     = d2 ^ flip_mask;

  dft_frame_sequencer #(.DW(DW), .FFT_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_clr    (sync_clr),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .fft_x       (fft_x),
    .fft_y       (fft_y),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_index     (m_index),
    .m_last      (m_last),
    .busy        (busy),
    .frame_count (frame_count),
    .err_count   (err_count),
    .err_flag    (err_flag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit gaps);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) check("s_ready_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_rand_frame(input bit gaps);
    for (int i = 0; i < 8; i++) send(DW'($urandom), gaps);
  endtask

  task automatic drain(input bit rnd);
    int guard = 0;
    rand_rdy = rnd;
    if (!rnd) m_ready = 1'b1;
    while ((expq.size() != 0 || busy) && guard < 2000) begin
      tick();
      guard++;
    end
    check("drain_done", guard < 2000, 1);
    rand_rdy = 1'b0;
    m_ready  = 1'b0;
  endtask

  task automatic pulse_clr();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
  endtask

  // Monitor: samples handshakes half a cycle before the edge that completes them.
  initial begin
    bit            hold_v = 1'b0;
    logic [DW+2:0] hold_val = '0;
    logic [DW+3:0] e;
    int            acc;
    forever begin
      @(negedge clk);
      if (!rst_n || sync_clr) begin
        pend.delete();
        if (sync_clr) expq.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("hold_stable", {m_valid, m_data, m_index}, {1'b1, hold_val});
        hold_v   = m_valid && !m_ready;
        hold_val = {m_data, m_index};
        if (m_valid && m_ready) begin
          if (expq.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            e = expq.pop_front();
            check("beat", {m_data, m_index, m_last}, e);
          end
        end
        if (s_valid && s_ready) begin
          pend.push_back(s_data);
          if (pend.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
              logic [DW-1:0] y;
              acc = 0;
              for (int j = 0; j < 8; j++) acc += sgn[k][j] * int'(pend[j]);
              y = acc[DW-1:0];
              if (k == 3 && bad_y3) y[0] = ~y[0];
              expq.push_back({y, 3'(k), (k == 7)});
            end
            pend.delete();
            frames_exp++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] t2 [8];
    int guard;
    t2 = '{8'h10, 8'h14, 8'hF8, 8'h00, 8'hFC, 8'hFC, 8'h00, 8'hF8};

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {s_ready, m_valid, m_data, m_index, m_last, busy, frame_count, err_count, err_flag}, 0);
    check("rst_fftx", fft_x, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sready_pre", s_ready, 0);
    tick();
    check("sready_post", {s_ready, busy}, 2'b10);

    // Samples 01..08, latency and the known result table.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("latency_m_valid", m_valid, (i == 4));
    end
    for (int k = 0; k < 8; k++) begin
      check("t2_result", {m_data, m_index, m_last}, {t2[k], 3'(k), (k == 7)});
      tick();
    end
    check("t2_empty", m_valid, 0);
    check("t2_frames", frame_count, 1);

    // Back-pressure across two frames.
    m_ready = 1'b0;
    send_rand_frame(1'b0);
    send_rand_frame(1'b0);
    repeat (6) tick();
    check("t3_stall", {s_ready, busy, m_valid}, 3'b011);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (4) tick();
    s_valid = 1'b0;
    check("t3_sready_low", s_ready, 0);
    drain(1'b0);
    check("t3_frames", frame_count, 3);

    // Partial frame aborted, then a full frame of FF.
    for (int i = 0; i < 5; i++) send(DW'($urandom), 1'b0);
    pulse_clr();
    check("t4_clr", {s_ready, busy, m_valid}, 3'b100);
    for (int i = 0; i < 8; i++) send(8'hFF, 1'b0);
    drain(1'b0);
    check("t4_frames", frame_count, 4);

    // Abort while results are pending on the output.
    m_ready = 1'b0;
    send_rand_frame(1'b0);
    guard = 0;
    while (!m_valid && guard < 50) begin
      tick();
      guard++;
    end
    check("t4b_valid_seen", m_valid, 1);
    pulse_clr();
    check("t4b_clr", {s_ready, busy, m_valid}, 3'b100);
    check("t4b_frames", frame_count, 5);

    // Reload in the same cycle as the last beat: no bubble on m_valid.
    send_rand_frame(1'b0);
    send_rand_frame(1'b0);
    repeat (6) tick();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t5_no_bubble", m_valid, 1);
      tick();
    end
    drain(1'b0);
    check("t5_frames", frame_count, 7);

    // Randomized frames with gaps, random m_ready and an aborted partial frame.
    rand_rdy = 1'b1;
    for (int f = 0; f < 10; f++) begin
      if (f == 4) begin
        for (int i = 0; i < int'($urandom_range(1, 7)); i++) send(DW'($urandom), 1'b1);
        pulse_clr();
      end
      send_rand_frame(1'b1);
    end
    drain(1'b1);
    check("rand_frames", frame_count, frames_exp);

`ifdef DFT_SEQ_SELFCHECK_EN
    check("sc_clean", {err_flag, err_count}, 0);
    bad_y3 = 1'b1;
    send_rand_frame(1'b0);
    drain(1'b0);
    check("sc_one", {err_flag, err_count}, {1'b1, 8'd1});
    m_ready = 1'b1;
    for (int f = 0; f < 254; f++) send_rand_frame(1'b0);
    drain(1'b0);
    check("sc_255", {err_flag, err_count}, {1'b1, 8'hFF});
    m_ready = 1'b1;
    send_rand_frame(1'b0);
    drain(1'b0);
    check("sc_saturate", {err_flag, err_count}, {1'b1, 8'hFF});
    bad_y3 = 1'b0;
`else
    bad_y3 = 1'b1;
    send_rand_frame(1'b0);
    drain(1'b0);
    bad_y3 = 1'b0;
    check("err_tied_off", {err_flag, err_count}, 0);
`endif
    check("final_frames", frame_count, CNT_W'(frames_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
